// File: rtl/weight_fetch_arbiter.sv
// Round-robin arbiter that shares one weight RAM read port between NUM_REQ burst requesters.
// Each granted burst streams one address per cycle, and the read data is steered back to the burst's owner.
module weight_fetch_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_base,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  i_req_len,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic [NUM_REQ-1:0]            o_rd_valid,
  output logic                          o_rd_last,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_busy,
  output logic [ADDR_WIDTH-1:0]         o_ram_address,
  output logic                          o_ram_address_valid,
  input  logic [DATA_WIDTH-1:0]         i_ram_read_data,
  input  logic                          i_ram_read_data_valid
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_owner;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_addr_valid;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_busy;

  logic                  w_any;
  logic [PTR_W-1:0]      w_win;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_win_base;
  logic [LEN_WIDTH-1:0]  w_win_len;
  logic                  w_beat;
  logic                  w_last_beat;

  // First requesting index at or after the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_any && i_req_valid[(32'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_win = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_grant    = (r_state == S_IDLE) && w_any && !i_rst;
  assign w_win_base = i_req_base[32'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_len  = i_req_len[32'(w_win)*LEN_WIDTH +: LEN_WIDTH];

  // Return data only counts while a burst owns the port; anything else is a stray and dropped.
  assign w_beat      = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) && i_ram_read_data_valid && !i_rst;
  assign w_last_beat = (r_beat_cnt == r_len - LEN_WIDTH'(1));

  assign o_req_ready         = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign o_rd_valid          = w_beat ? (NUM_REQ'(1) << r_owner) : '0;
  assign o_rd_data           = i_rst ? '0 : i_ram_read_data;
  assign o_rd_last           = w_beat && w_last_beat;
  assign o_done              = r_done;
  assign o_busy              = r_busy;
  assign o_ram_address       = r_addr;
  assign o_ram_address_valid = r_addr_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_len        <= '0;
      r_issue_cnt  <= '0;
      r_beat_cnt   <= '0;
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_done       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner     <= w_win;
            r_len       <= w_win_len;
            r_addr      <= w_win_base;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_busy      <= 1'b1;
            r_rr_ptr    <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
            if (w_win_len == '0) begin
              r_state <= S_ZERO;
              r_done  <= NUM_REQ'(1) << w_win;
            end else begin
              r_state      <= S_ISSUE;
              r_addr_valid <= 1'b1;
            end
          end
        end
        S_ZERO: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ISSUE: begin
          r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
          if (w_beat) r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
          if (r_issue_cnt == r_len - LEN_WIDTH'(1)) begin
            r_state      <= S_DRAIN;
            r_addr_valid <= 1'b0;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (w_beat) r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
          // Done is raised in the following IDLE cycle, which may also grant the next burst.
          if ((r_beat_cnt == r_len) || (w_beat && w_last_beat)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= NUM_REQ'(1) << r_owner;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
